drum_trunc_stage: RTL and testbench

Operand-truncation stage of the DRUM approximate multiplier, directly downstream of the 16-to-4 one-hot position encoder. It takes an operand and the 4-bit leading-one position the encoder produced for it. It emits a K-bit mantissa, with its LSB forced to 1 for unbiasing, and the shift amount the back-end shifter needs to restore magnitude. Results go through a registered valid/ready interface with a 2-entry output buffer, so multiplier back-pressure never stalls the combinational front end mid-beat.

---
 rtl/drum_trunc_stage.sv | 87 ++++++++
 tb/tb_drum_trunc_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_trunc_stage.sv
// DRUM operand truncation: K-bit mantissa plus restore-shift, behind a 2-entry output FIFO.
// Build option: define DRUM_UNBIAS_EN to force mant[0]=1 on the truncating path.
module drum_trunc_stage #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [3:0]       lead_pos_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [K-1:0]     mant_o,
    output logic [3:0]       shift_o,
    output logic             zero_o
);

    logic [K-1:0] mant_c;
    logic [3:0]   shift_c;
    logic         zero_c;
    logic [3:0]   shift_amt;

    assign shift_amt = lead_pos_i - 4'(K - 1);

    always_comb begin
        mant_c  = '0;
        shift_c = '0;
        zero_c  = 1'b0;
        if (operand_i == '0) begin
            zero_c = 1'b1;
        end else if (lead_pos_i < 4'(K)) begin
            mant_c = operand_i[K-1:0];
        end else begin
            // Barrel-select of the K bits ending at the leading one.
            mant_c  = K'(operand_i >> shift_amt);
            shift_c = shift_amt;
`ifdef DRUM_UNBIAS_EN
            mant_c[0] = 1'b1;
`endif
        end
    end

    logic [K-1:0] mem_mant  [2];
    logic [3:0]   mem_shift [2];
    logic         mem_zero  [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Reset gating keeps the handshake and data quiet while rst_i is held.
    assign in_ready_o  = !rst_i && (count != 2'd2);
    assign out_valid_o = !rst_i && (count != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign mant_o  = out_valid_o ? mem_mant[rd_ptr]  : '0;
    assign shift_o = out_valid_o ? mem_shift[rd_ptr] : '0;
    assign zero_o  = out_valid_o ? mem_zero[rd_ptr]  : 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_mant[wr_ptr]  <= mant_c;
                mem_shift[wr_ptr] <= shift_c;
                mem_zero[wr_ptr]  <= zero_c;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_trunc_stage.sv
// Self-checking bench for drum_trunc_stage (K=6): queue model plus directed vectors.
module tb_drum_trunc_stage;
    localparam int K = 6;

    typedef struct packed {
        logic [K-1:0] mant;
        logic [3:0]   shift;
        logic         zero;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] operand_i = '0;
    logic [3:0]  lead_pos_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [K-1:0] mant_o;
    logic [3:0]  shift_o;
    logic        zero_o;

    int checks = 0;
    int failures = 0;
    int del_cnt = 0;
    ent_t q[$];

    drum_trunc_stage #(.WIDTH(16), .K(K)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operand_i(operand_i), .lead_pos_i(lead_pos_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .mant_o(mant_o), .shift_o(shift_o), .zero_o(zero_o)
    );

    always #5 clk_i = !clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t model(input logic [15:0] op, input logic [3:0] pos);
        ent_t e;
        int v, p, sh;
        v = int'(op);
        p = int'(pos);
        e = '0;
        if (v == 0) begin
            e.zero = 1'b1;
        end else if (p < K) begin
            e.mant = K'(v % (1 << K));
        end else begin
            sh = p - K + 1;
            e.mant  = K'((v / (1 << sh)) % (1 << K));
            e.shift = 4'(sh);
`ifdef DRUM_UNBIAS_EN
            e.mant = e.mant | K'(1);
`endif
        end
        return e;
    endfunction

    function automatic logic [3:0] lead_of(input logic [15:0] op);
        logic [3:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) if (op[b]) r = 4'(b);
        return r;
    endfunction

    // Model of the buffer: an ordered queue of at most two results.
    always @(posedge clk_i) begin
        bit m_rdy, m_val;
        if (rst_i) begin
            q.delete();
        end else begin
            m_rdy = (q.size() != 2);
            m_val = (q.size() != 0);
            if (m_val && out_ready_i) begin
                void'(q.pop_front());
                del_cnt++;
            end
            if (in_valid_i && m_rdy) q.push_back(model(operand_i, lead_pos_i));
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_i) begin
        ent_t h;
        bit ev;
        ev = !rst_i && (q.size() != 0);
        h  = ev ? q[0] : ent_t'('0);
        chk("in_ready", 32'(in_ready_o), 32'(!rst_i && (q.size() != 2)));
        chk("out_valid", 32'(out_valid_o), 32'(ev));
        chk("mant", 32'(mant_o), 32'(h.mant));
        chk("shift", 32'(shift_o), 32'(h.shift));
        chk("zero", 32'(zero_o), 32'(h.zero));
    end

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i); #1;
        end
        if (!acc) chk("accept_timeout", 32'(0), 32'(1));
        in_valid_i = 1'b0;
    endtask

    task automatic send(input logic [15:0] op);
        in_valid_i = 1'b1;
        operand_i  = op;
        lead_pos_i = lead_of(op);
        wait_accept();
    endtask

    task automatic lit_beat(input string name, input logic [15:0] op, input logic [3:0] pos,
                            input logic [K-1:0] em, input logic [3:0] es, input logic ez);
        ent_t m;
        m = model(op, pos);
        chk({name, "_model"}, 32'(m), 32'({em, es, ez}));
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        operand_i   = op;
        lead_pos_i  = pos;
        @(negedge clk_i);
        chk({name, "_pre_valid"}, 32'(out_valid_o), 32'(0));
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_valid"}, 32'(out_valid_o), 32'(1));
        chk({name, "_mant"}, 32'(mant_o), 32'(em));
        chk({name, "_shift"}, 32'(shift_o), 32'(es));
        chk({name, "_zero"}, 32'(zero_o), 32'(ez));
        @(posedge clk_i); #1;
    endtask

    initial begin
        int d0, nr;
        logic [15:0] op;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_ready", 32'(in_ready_o), 32'(1));
        chk("post_reset_valid", 32'(out_valid_o), 32'(0));
        @(posedge clk_i); #1;

`ifdef DRUM_UNBIAS_EN
        lit_beat("trunc_0f00", 16'h0F00, 4'd11, 6'b111101, 4'd6, 1'b0);
        lit_beat("msb_8000", 16'h8000, 4'd15, 6'b100001, 4'd10, 1'b0);
        lit_beat("bad_pos", 16'h0F00, 4'd9, 6'b110001, 4'd4, 1'b0);
`else
        lit_beat("trunc_0f00", 16'h0F00, 4'd11, 6'b111100, 4'd6, 1'b0);
        lit_beat("msb_8000", 16'h8000, 4'd15, 6'b100000, 4'd10, 1'b0);
        lit_beat("bad_pos", 16'h0F00, 4'd9, 6'b110000, 4'd4, 1'b0);
`endif
        lit_beat("small_0023", 16'h0023, 4'd5, 6'b100011, 4'd0, 1'b0);
        lit_beat("zero_0000", 16'h0000, 4'd0, 6'b000000, 4'd0, 1'b1);

        // Back-pressure: A and B fill the buffer, C must wait.
        out_ready_i = 1'b0;
        d0 = del_cnt;
        send(16'h1234);
        send(16'h00F7);
        in_valid_i = 1'b1;
        operand_i  = 16'hA5A5;
        lead_pos_i = lead_of(16'hA5A5);
        repeat (3) begin
            @(negedge clk_i);
            chk("bp_ready_low", 32'(in_ready_o), 32'(0));
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk_i);
        #1 chk("bp_deliveries", 32'(del_cnt - d0), 32'(3));

        // Streaming: 20 back-to-back beats.
        d0 = del_cnt;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            op = (i % 7 == 3) ? 16'h0000 : 16'((i * 2749 + 13) << (i % 5));
            in_valid_i = 1'b1;
            operand_i  = op;
            lead_pos_i = lead_of(op);
            @(negedge clk_i);
            if (!in_ready_o) nr++;
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("stream_deliveries", 32'(del_cnt - d0), 32'(20));
        chk("stream_not_ready", 32'(nr), 32'(0));

        // Simultaneous push and pop with one entry held.
        out_ready_i = 1'b0;
        send(16'h0300);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        operand_i   = 16'h4C01;
        lead_pos_i  = lead_of(16'h4C01);
        @(posedge clk_i); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("pushpop_valid", 32'(out_valid_o), 32'(1));
        chk("pushpop_ready", 32'(in_ready_o), 32'(1));
        chk("pushpop_mant", 32'(mant_o), 32'(model(16'h4C01, 4'd14).mant));
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset with two entries buffered.
        out_ready_i = 1'b0;
        send(16'h7777);
        send(16'h0042);
        d0 = del_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("in_reset_valid", 32'(out_valid_o), 32'(0));
        chk("in_reset_ready", 32'(in_ready_o), 32'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("after_rst_valid", 32'(out_valid_o), 32'(0));
        chk("after_rst_ready", 32'(in_ready_o), 32'(1));
        chk("after_rst_data", 32'({mant_o, shift_o, zero_o}), 32'(0));
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 chk("rst_discard", 32'(del_cnt - d0), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
